// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: 640x480@60 default constants,
// per-axis region encoding and the colour-bar test pattern table.
package vga_timing_pkg;

    // 640x480@60 defaults (25.175 MHz pixel clock)
    localparam int unsigned DEF_COLOR_W  = 10;
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FRONT  = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BACK   = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FRONT  = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BACK   = 33;

    // Region of one axis, in the order it is traversed
    typedef enum logic [1:0] {
        REGION_ACTIVE,
        REGION_FRONT,
        REGION_SYNC,
        REGION_BACK
    } region_e;

    // Colour bars as {R,G,B} on/off bits, left to right
    localparam logic [2:0] BAR_WHITE   = 3'b111;
    localparam logic [2:0] BAR_YELLOW  = 3'b110;
    localparam logic [2:0] BAR_CYAN    = 3'b011;
    localparam logic [2:0] BAR_GREEN   = 3'b010;
    localparam logic [2:0] BAR_MAGENTA = 3'b101;
    localparam logic [2:0] BAR_RED     = 3'b100;
    localparam logic [2:0] BAR_BLUE    = 3'b001;
    localparam logic [2:0] BAR_BLACK   = 3'b000;

    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        case (idx)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrap counter over active/front/sync/back with region
// decode and a terminal-count flag (count at its last value).
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned FRONT  = DEF_H_FRONT,
    parameter int unsigned SYNC   = DEF_H_SYNC,
    parameter int unsigned BACK   = DEF_H_BACK,
    parameter int unsigned W      = $clog2(ACTIVE + FRONT + SYNC + BACK)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count,
    output region_e      region,
    output logic         terminal
);

    localparam int unsigned TOTAL = ACTIVE + FRONT + SYNC + BACK;

    localparam logic [W-1:0] FRONT_START = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_START  = W'(ACTIVE + FRONT);
    localparam logic [W-1:0] BACK_START  = W'(ACTIVE + FRONT + SYNC);
    localparam logic [W-1:0] LAST        = W'(TOTAL - 1);

    assign terminal = (count == LAST);

    // Advance when enabled, wrapping to zero after the last position
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= terminal ? '0 : count + 1'b1;
        end
    end

    // Classify the current position into its region
    always_comb begin
        region = REGION_BACK;
        if (count < FRONT_START) begin
            region = REGION_ACTIVE;
        end else if (count < SYNC_START) begin
            region = REGION_FRONT;
        end else if (count < BACK_START) begin
            region = REGION_SYNC;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel request with REQ_LEAD cycles of
// lead, sync/blank generation, colour registration onto the DAC pins and a
// sticky upstream-underflow flag.
// Optional: define VGA_TEST_PATTERN_EN to add inPatternMode, which replaces
// the upstream colour with 8 full-scale vertical colour bars.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned COLOR_W  = DEF_COLOR_W,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FRONT  = DEF_H_FRONT,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BACK   = DEF_H_BACK,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FRONT  = DEF_V_FRONT,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BACK   = DEF_V_BACK,
    parameter logic        H_POL    = 1'b0,
    parameter logic        V_POL    = 1'b0,
    parameter int unsigned REQ_LEAD = 2,
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
    localparam int unsigned XW      = $clog2(H_TOTAL),
    localparam int unsigned YW      = $clog2(V_TOTAL)
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic [COLOR_W-1:0] inRed,
    input  logic [COLOR_W-1:0] inGreen,
    input  logic [COLOR_W-1:0] inBlue,
    input  logic               inValid,
    input  logic               inClrErr,
`ifdef VGA_TEST_PATTERN_EN
    input  logic               inPatternMode,
`endif
    output logic               outRequest,
    output logic [XW-1:0]      outX,
    output logic [YW-1:0]      outY,
    output logic               outFrameStart,
    output logic               outUnderflow,
    output logic [COLOR_W-1:0] outVGA_R,
    output logic [COLOR_W-1:0] outVGA_G,
    output logic [COLOR_W-1:0] outVGA_B,
    output logic               outVGA_H_SYNC,
    output logic               outVGA_V_SYNC,
    output logic               outVGA_SYNC,
    output logic               outVGA_BLANK
);

    logic [XW-1:0] h_count;
    logic [YW-1:0] v_count;
    region_e       h_region;
    region_e       v_region;
    logic          h_term;
    logic          v_term;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK),
        .W      (XW)
    ) u_h_counter (
        .clk      (iCLK),
        .rst      (iRST),
        .en       (1'b1),
        .count    (h_count),
        .region   (h_region),
        .terminal (h_term)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK),
        .W      (YW)
    ) u_v_counter (
        .clk      (iCLK),
        .rst      (iRST),
        .en       (h_term),
        .count    (v_count),
        .region   (v_region),
        .terminal (v_term)
    );

    // Bit 0 is stage 0 (the request cycle); bit REQ_LEAD drives the pins
    logic [REQ_LEAD:0] act_pipe;
    logic [REQ_LEAD:0] hs_pipe;
    logic [REQ_LEAD:0] vs_pipe;
    logic              at_origin;
    logic              sample_active;

    assign sample_active = act_pipe[REQ_LEAD-1];
    assign outRequest    = act_pipe[0];
    assign outVGA_BLANK  = act_pipe[REQ_LEAD];
    assign outVGA_H_SYNC = hs_pipe[REQ_LEAD];
    assign outVGA_V_SYNC = vs_pipe[REQ_LEAD];
    assign outVGA_SYNC   = 1'b0;

    // Stage 0 request/coordinates and the sync/blank delay line.
    // at_origin flags counters at (0,0) from reset or the frame wrap,
    // so no full-width compare of both counters is needed.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            at_origin     <= 1'b1;
            act_pipe      <= '0;
            hs_pipe       <= {(REQ_LEAD + 1){~H_POL}};
            vs_pipe       <= {(REQ_LEAD + 1){~V_POL}};
            outX          <= '0;
            outY          <= '0;
            outFrameStart <= 1'b0;
        end else begin
            at_origin     <= h_term & v_term;
            act_pipe      <= {act_pipe[REQ_LEAD-1:0],
                              (h_region == REGION_ACTIVE) && (v_region == REGION_ACTIVE)};
            hs_pipe       <= {hs_pipe[REQ_LEAD-1:0],
                              (h_region == REGION_SYNC) ? H_POL : ~H_POL};
            vs_pipe       <= {vs_pipe[REQ_LEAD-1:0],
                              (v_region == REGION_SYNC) ? V_POL : ~V_POL};
            outX          <= h_count;
            outY          <= v_count;
            outFrameStart <= at_origin;
        end
    end

    logic [COLOR_W-1:0] src_r;
    logic [COLOR_W-1:0] src_g;
    logic [COLOR_W-1:0] src_b;
    logic               src_ok;

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar_pipe [REQ_LEAD];
    logic [2:0] bar_bits;

    // Bar index travels alongside stage 0 so it lines up with the sample
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            for (int unsigned i = 0; i < REQ_LEAD; i++) begin
                bar_pipe[i] <= '0;
            end
        end else begin
            for (int unsigned i = REQ_LEAD - 1; i > 0; i--) begin
                bar_pipe[i] <= bar_pipe[i-1];
            end
            bar_pipe[0] <= 3'((32'(h_count) * 32'd8) / H_ACTIVE);
        end
    end
`endif

    // Select the colour source for the pixel being sampled this cycle
    always_comb begin
        src_r  = inRed;
        src_g  = inGreen;
        src_b  = inBlue;
        src_ok = inValid;
`ifdef VGA_TEST_PATTERN_EN
        bar_bits = bar_rgb(bar_pipe[REQ_LEAD-1]);
        if (inPatternMode) begin
            src_r  = {COLOR_W{bar_bits[2]}};
            src_g  = {COLOR_W{bar_bits[1]}};
            src_b  = {COLOR_W{bar_bits[0]}};
            src_ok = 1'b1;
        end
`endif
    end

    // Register colour onto the DAC; blank and starved pixels are black
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            outVGA_R <= '0;
            outVGA_G <= '0;
            outVGA_B <= '0;
        end else if (sample_active && src_ok) begin
            outVGA_R <= src_r;
            outVGA_G <= src_g;
            outVGA_B <= src_b;
        end else begin
            outVGA_R <= '0;
            outVGA_G <= '0;
            outVGA_B <= '0;
        end
    end

    // Sticky underflow: a starved active pixel sets it, set beats clear
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            outUnderflow <= 1'b0;
        end else if (sample_active && !src_ok) begin
            outUnderflow <= 1'b1;
        end else if (inClrErr) begin
            outUnderflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen with a 16x8 total raster
// (H 8/2/3/3, V 4/1/2/1, REQ_LEAD=2). The stimulus process pushes the
// expected outputs of every cycle; the monitor pops and compares them.
module tb_vga_timing_gen;

    logic       iCLK = 1'b0;
    logic       iRST;
    logic [9:0] inRed, inGreen, inBlue;
    logic       inValid, inClrErr;
`ifdef VGA_TEST_PATTERN_EN
    logic       inPatternMode;
`endif
    logic       outRequest, outFrameStart, outUnderflow;
    logic [3:0] outX;
    logic [2:0] outY;
    logic [9:0] outVGA_R, outVGA_G, outVGA_B;
    logic       outVGA_H_SYNC, outVGA_V_SYNC, outVGA_SYNC, outVGA_BLANK;

    always #5 iCLK = ~iCLK;

    vga_timing_gen #(
        .COLOR_W  (10),
        .H_ACTIVE (8),
        .H_FRONT  (2),
        .H_SYNC   (3),
        .H_BACK   (3),
        .V_ACTIVE (4),
        .V_FRONT  (1),
        .V_SYNC   (2),
        .V_BACK   (1),
        .H_POL    (1'b0),
        .V_POL    (1'b0),
        .REQ_LEAD (2)
    ) dut (
        .iCLK          (iCLK),
        .iRST          (iRST),
        .inRed         (inRed),
        .inGreen       (inGreen),
        .inBlue        (inBlue),
        .inValid       (inValid),
        .inClrErr      (inClrErr),
`ifdef VGA_TEST_PATTERN_EN
        .inPatternMode (inPatternMode),
`endif
        .outRequest    (outRequest),
        .outX          (outX),
        .outY          (outY),
        .outFrameStart (outFrameStart),
        .outUnderflow  (outUnderflow),
        .outVGA_R      (outVGA_R),
        .outVGA_G      (outVGA_G),
        .outVGA_B      (outVGA_B),
        .outVGA_H_SYNC (outVGA_H_SYNC),
        .outVGA_V_SYNC (outVGA_V_SYNC),
        .outVGA_SYNC   (outVGA_SYNC),
        .outVGA_BLANK  (outVGA_BLANK)
    );

    typedef struct {
        logic       req;
        logic [3:0] x;
        logic [2:0] y;
        logic       fs;
        logic       hs;
        logic       vs;
        logic       blank;
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
        logic       uf;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Raster position p counts pixels since the frame start, 128 per frame
    function automatic int h_of(input int p);
        return p % 16;
    endfunction

    function automatic int v_of(input int p);
        return (p / 16) % 8;
    endfunction

    function automatic bit act_of(input int p);
        return (h_of(p) < 8) && (v_of(p) < 4);
    endfunction

    // White, yellow, cyan, green, magenta, red, blue, black as {R,G,B}
    function automatic logic [2:0] bar_of(input int x);
        case (x)
            0:       return 3'b111;
            1:       return 3'b110;
            2:       return 3'b011;
            3:       return 3'b010;
            4:       return 3'b101;
            5:       return 3'b100;
            6:       return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic void chk(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    endfunction

    // Monitor: the DUT presents a full output vector every cycle
    always @(negedge iCLK) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("request",     outRequest,    e.req);
            chk("x",           outX,          e.x);
            chk("y",           outY,          e.y);
            chk("frame_start", outFrameStart, e.fs);
            chk("h_sync",      outVGA_H_SYNC, e.hs);
            chk("v_sync",      outVGA_V_SYNC, e.vs);
            chk("blank",       outVGA_BLANK,  e.blank);
            chk("red",         outVGA_R,      e.r);
            chk("green",       outVGA_G,      e.g);
            chk("blue",        outVGA_B,      e.b);
            chk("underflow",   outUnderflow,  e.uf);
            chk("sync_const",  outVGA_SYNC,   0);
        end
    end

    // Model state: k = non-reset edges since the last reset edge
    int         k;
    bit         uf_m;
    logic [9:0] cr, cg, cb;
    bit         d_rst, d_valid, d_clr, d_pat, did_mid;
    logic [9:0] d_r, d_g, d_b;
    int         rst_hold;

    task automatic apply_inputs();
        iRST     = d_rst;
        inValid  = d_valid;
        inClrErr = d_clr;
        inRed    = d_r;
        inGreen  = d_g;
        inBlue   = d_b;
`ifdef VGA_TEST_PATTERN_EN
        inPatternMode = d_pat;
`endif
    endtask

    initial begin
        exp_t       e;
        int         p;
        int         n;
        logic [2:0] bb;

        k = 0; uf_m = 0; cr = '0; cg = '0; cb = '0;
        d_rst = 1; d_valid = 1; d_clr = 0; d_pat = 0; did_mid = 0;
        d_r = '0; d_g = '0; d_b = '0;
        rst_hold = 2;
        apply_inputs();

        n = 0;
        while (!(did_mid && !d_rst && k >= 300) && n < 3000) begin
            n++;
            @(posedge iCLK);
            // Edge update of the reference model from last cycle's drives
            if (d_rst) begin
                k = 0; uf_m = 0; cr = '0; cg = '0; cb = '0;
            end else begin
                cr = '0; cg = '0; cb = '0;
                if (k >= 2 && act_of(k - 2)) begin
                    if (d_pat) begin
                        bb = bar_of(h_of(k - 2));
                        cr = bb[2] ? 10'h3FF : 10'h000;
                        cg = bb[1] ? 10'h3FF : 10'h000;
                        cb = bb[0] ? 10'h3FF : 10'h000;
                    end else if (d_valid) begin
                        cr = d_r; cg = d_g; cb = d_b;
                    end
                    if (!d_pat && !d_valid) uf_m = 1;
                    else if (d_clr) uf_m = 0;
                end else if (d_clr) begin
                    uf_m = 0;
                end
                k++;
            end
            #1;
            // Expected outputs for this cycle
            if (k == 0) begin
                e = '{req: 0, x: 0, y: 0, fs: 0, hs: 1, vs: 1, blank: 0,
                      r: 0, g: 0, b: 0, uf: 0};
            end else begin
                e.req = act_of(k - 1);
                e.x   = 4'(h_of(k - 1));
                e.y   = 3'(v_of(k - 1));
                e.fs  = ((k - 1) % 128) == 0;
                if (k >= 3) begin
                    e.hs    = !(h_of(k - 3) >= 10 && h_of(k - 3) <= 12);
                    e.vs    = !(v_of(k - 3) >= 5 && v_of(k - 3) <= 6);
                    e.blank = act_of(k - 3);
                end else begin
                    e.hs = 1; e.vs = 1; e.blank = 0;
                end
                e.r = cr; e.g = cg; e.b = cb;
                e.uf = uf_m;
            end
            sb.push_back(e);

            // Next drives; this cycle samples colour for pixel p = k-2
            p = k - 2;
            if (rst_hold > 0) begin
                d_rst = 1; rst_hold--;
            end else if (!did_mid && (k - 1) == 421) begin
                // stage 0 is showing (5,2) of the fourth frame
                d_rst = 1; rst_hold = 2; did_mid = 1;
            end else begin
                d_rst = 0;
            end
            d_valid = !(!did_mid && (p == 275 || p == 292));
            d_clr   = !did_mid && (p == 292 || p == 316 || p == 356);
`ifdef VGA_TEST_PATTERN_EN
            d_pat   = did_mid && !d_rst && k >= 140;
`else
            d_pat   = 0;
`endif
            if (d_pat) begin
                d_valid = 0; d_r = '0; d_g = '0; d_b = '0;
            end else if (k >= 2 && act_of(p)) begin
                d_r = 10'(h_of(p));
                d_g = 10'(v_of(p) * 64 + h_of(p));
                d_b = 10'(1023 - h_of(p) * 16);
            end else begin
                d_r = 10'h2AA; d_g = 10'h2AA; d_b = 10'h2AA;
            end
            apply_inputs();
        end

        if (n >= 3000) begin
            n_checks++;
            $display("FAIL run_length: got %0d cycles, expected fewer than 3000", n);
        end
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge iCLK);
        #1;
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA controller.
- Generates H/V timing with configurable porches, sync widths and sync polarity.
- Issues a pixel request with a parametrised lead, plus pixel coordinates, to the upstream frame/chroma-key pipeline.
- Registers returned colour onto the DAC pins; detects upstream underflow; sits between the pixel source and the ADV7123-style VGA DAC.

Parameters:
- COLOR_W, 10, bits per colour channel.
- H_ACTIVE, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch (pixels).
- H_SYNC, 96, horizontal sync width.
- H_BACK, 48, horizontal back porch.
- V_ACTIVE, 480, visible lines.
- V_FRONT, 10, vertical front porch (lines).
- V_SYNC, 2, vertical sync width.
- V_BACK, 33, vertical back porch.
- H_POL, 0, active level of outVGA_H_SYNC.
- V_POL, 0, active level of outVGA_V_SYNC.
- REQ_LEAD, 2, cycles from outRequest to matching pixel on outVGA_*; legal range 1..8.

Ports:
- iCLK, in, 1, pixel clock.
- iRST, in, 1, synchronous active-high reset.
- inRed, in, COLOR_W, red for the pixel requested REQ_LEAD-1 cycles earlier.
- inGreen, in, COLOR_W, green, same timing.
- inBlue, in, COLOR_W, blue, same timing.
- inValid, in, 1, colour inputs valid, same timing.
- inClrErr, in, 1, clears outUnderflow.
- outRequest, out, 1, pixel request, one per active pixel.
- outX, out, XW=$clog2(H_TOTAL), column of the requested pixel.
- outY, out, YW=$clog2(V_TOTAL), row of the requested pixel.
- outFrameStart, out, 1, one-cycle pulse with the request for (0,0).
- outUnderflow, out, 1, sticky underflow flag.
- outVGA_R / outVGA_G / outVGA_B, out, COLOR_W, DAC colour.
- outVGA_H_SYNC, out, 1, horizontal sync.
- outVGA_V_SYNC, out, 1, vertical sync.
- outVGA_SYNC, out, 1, constant 0.
- outVGA_BLANK, out, 1, high in the active area.

Behaviour:
- Derived constants:
  - H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK.
  - V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK.
- Counters:
  - H counter runs 0..H_TOTAL-1, then wraps to 0.
  - V counter increments when H wraps and runs 0..V_TOTAL-1, then wraps.
- Region order per axis: active [0,ACTIVE), front porch, sync, back porch.
- Stage 0 (registered from counters):
  - outRequest = H<H_ACTIVE && V<V_ACTIVE.
  - outX/outY = counter values.
  - outFrameStart = (H==0 && V==0).
- Timing pipeline:
  - Sync and blank decodes are delayed through a REQ_LEAD-deep shift register.
  - outVGA_H_SYNC = H_POL while H in the sync region, otherwise ~H_POL. Same rule for V with V_POL.
  - outVGA_BLANK = delayed active flag.
- Colour path:
  - Colour inputs are sampled at the edge ending cycle t+REQ_LEAD-1 for a request in cycle t, and appear on outVGA_* in cycle t+REQ_LEAD.
  - In the blank region, colour outputs are 0 regardless of the inputs.
- Underflow:
  - Trigger: delayed active flag high and inValid low in the sampling cycle.
  - That pixel is output as 0 and outUnderflow is set.
  - outUnderflow stays set until inClrErr. If set and clear occur in the same cycle, set wins.
- Reset (iRST high at an edge):
  - Counters are 0 and the pipeline is flushed.
  - outRequest, outX, outY, outFrameStart, outUnderflow, colour and outVGA_BLANK are 0.
  - Syncs are at their inactive level.
  - Reset asserted mid-frame aborts the frame. In the first cycle after release: outRequest=1, outX=0, outY=0, outFrameStart=1.
- Wrap boundaries:
  - At H=H_TOTAL-1, V=V_TOTAL-1, the next cycle is (0,0) with no gap.
  - outFrameStart fires once per frame.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- With the macro defined:
  - Extra input inPatternMode (1 bit) is present.
  - When inPatternMode is high, colour = 8 vertical bars indexed by outX*8/H_ACTIVE (white, yellow, cyan, green, magenta, red, blue, black at full-scale), delayed with the pipeline.
  - In pattern mode, inValid is ignored and no underflow is flagged.
- Without the macro: port absent; colour always comes from the inputs.

Decomposition:
- Shared package vga_timing_pkg:
  - 640x480@60 default constants.
  - Region enum (ACTIVE, FRONT, SYNC, BACK).
  - Colour-bar constants.
- Sub-module vga_axis_counter:
  - Generic wrap counter with region decode and a terminal-count output.
  - Instantiated twice: H, and V enabled by the H terminal count.

Test Plan:
All scenarios use H 8/2/3/3 (total 16), V 4/1/2/1 (total 8), REQ_LEAD=2 unless stated.
- Reset release:
  - outRequest, outX=0, outY=0 and outFrameStart high in cycle 1.
  - outRequest high for 8 cycles, low for 8, for 4 lines; then low for 64 cycles; next outFrameStart at cycle 129.
- Sync alignment (H_POL=0, V_POL=0):
  - outVGA_H_SYNC low for exactly 3 cycles starting 12 cycles after each line's first request.
  - outVGA_V_SYNC low for 32 cycles starting at line 5 + 2 cycles.
- Data path:
  - Drive inRed=outX delayed 1 cycle, inValid=1.
  - outVGA_R shows 0..7 while outVGA_BLANK=1, and 0 otherwise.
  - outUnderflow stays 0.
- Underflow:
  - Drop inValid for one sample at pixel (3,1) -> that pixel outputs 0, outUnderflow=1 and stays 1.
  - Pulse inClrErr -> 0 next cycle.
  - inClrErr coincident with a new underflow -> remains 1.
- Mid-frame reset:
  - Assert iRST at (5,2) for 3 cycles -> all outputs at reset values, syncs inactive.
  - After release, frame restarts at (0,0) with outFrameStart.
- VGA_TEST_PATTERN_EN with inPatternMode=1 and inputs held at 0, inValid=0:
  - Line shows the 8 bar colours, one per pixel.
  - outUnderflow stays 0.
